// File: rtl/branch_sequencer.sv
// Bracket-branch sequencer: forward-scans instruction memory for the matching
// CBB (SKIP), or reloads the PC from a two-byte loop-cache entry (RESTORE).
module branch_sequencer #(
   parameter int PC_W    = 16,
   parameter int DEPTH_W = 8
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            start,
   input  logic            mode,
   input  logic [PC_W-1:0] pc_in,
   input  logic [PC_W-1:0] cache_addr,
   output logic [PC_W-1:0] fetch_addr,
   input  logic [3:0]      instr,
   output logic [PC_W-1:0] mem_addr,
   input  logic [7:0]      mem_rdata,
   output logic            loader_select,
   output logic            busy,
   output logic            done,
   output logic            error,
   output logic            pc_write,
   output logic [PC_W-1:0] pc_next
);

   // instruction opcodes
   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_INC = 4'd1;
   localparam logic [3:0] OP_DEC = 4'd2;
   localparam logic [3:0] OP_MVR = 4'd3;
   localparam logic [3:0] OP_MVL = 4'd4;
   localparam logic [3:0] OP_OUT = 4'd5;
   localparam logic [3:0] OP_IN  = 4'd6;
   localparam logic [3:0] OP_CBF = 4'd7;
   localparam logic [3:0] OP_CBB = 4'd8;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SKIP    = 3'd1;
   localparam logic [2:0] S_LOAD_LO = 3'd2;
   localparam logic [2:0] S_LOAD_HI = 3'd3;
   localparam logic [2:0] S_COMMIT  = 3'd4;

   localparam logic [PC_W-1:0]    PC_ONE    = PC_W'(1);
   localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

   logic [2:0]         state;
   logic [PC_W-1:0]    scan_pc;
   logic [DEPTH_W-1:0] depth;
   logic [PC_W-1:0]    cache_q;
   logic [7:0]         lo_q;
   logic [7:0]         hi_q;

   logic is_cbf;
   logic is_cbb;
   logic close_hit;
   logic skip_err;

   always_comb begin
      is_cbf    = (instr == OP_CBF);
      is_cbb    = (instr == OP_CBB);
      close_hit = is_cbb && (depth == '0);
      // any step that would advance scan_pc past all-ones, or nest too deep, faults
      skip_err  = !close_hit && ((&scan_pc) || (is_cbf && (&depth)));
   end

   always_comb begin
      busy          = 1'b0;
      done          = 1'b0;
      error         = 1'b0;
      pc_write      = 1'b0;
      pc_next       = '0;
      fetch_addr    = '0;
      mem_addr      = '0;
      loader_select = 1'b0;
      case (state)
         S_SKIP: begin
            busy       = 1'b1;
            fetch_addr = scan_pc;
            if (close_hit) begin
               done     = 1'b1;
               pc_write = 1'b1;
               pc_next  = scan_pc + PC_ONE;
            end else if (skip_err) begin
               done  = 1'b1;
               error = 1'b1;
            end
         end
         S_LOAD_LO: begin
            busy     = 1'b1;
            mem_addr = cache_q;
         end
         S_LOAD_HI: begin
            busy          = 1'b1;
            mem_addr      = cache_q + PC_ONE;
            loader_select = 1'b1;
         end
         S_COMMIT: begin
            busy     = 1'b1;
            done     = 1'b1;
            pc_write = 1'b1;
            pc_next  = PC_W'({hi_q, lo_q});
         end
         default: ;
      endcase
      // a reset landing on a completion cycle must not leak a write
      if (!reset_n) begin
         done     = 1'b0;
         error    = 1'b0;
         pc_write = 1'b0;
         pc_next  = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         scan_pc <= '0;
         depth   <= '0;
         cache_q <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (mode) begin
                     cache_q <= cache_addr;
                     state   <= S_LOAD_LO;
                  end else begin
                     scan_pc <= pc_in + PC_ONE;
                     depth   <= '0;
                     state   <= S_SKIP;
                  end
               end
            end
            S_SKIP: begin
               if (close_hit || skip_err) begin
                  state <= S_IDLE;
               end else begin
                  scan_pc <= scan_pc + PC_ONE;
                  if (is_cbf)
                     depth <= depth + DEPTH_ONE;
                  else if (is_cbb)
                     depth <= depth - DEPTH_ONE;
               end
            end
            S_LOAD_LO: begin
               lo_q  <= mem_rdata;
               state <= S_LOAD_HI;
            end
            S_LOAD_HI: begin
               hi_q  <= mem_rdata;
               state <= S_COMMIT;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed + randomized bench for branch_sequencer; scans are predicted by a
// plain address/depth walk over the bench's own instruction memory.
module tb_branch_sequencer;
   localparam int PC_W = 16;
   localparam logic [3:0] NOP = 4'd0, INC = 4'd1, DEC = 4'd2, MVR = 4'd3,
                          CBF = 4'd7, CBB = 4'd8;

   logic            clock = 1'b0;
   logic            reset_n;
   logic            start;
   logic            mode;
   logic [PC_W-1:0] pc_in;
   logic [PC_W-1:0] cache_addr;
   logic [PC_W-1:0] fetch_addr;
   logic [3:0]      instr;
   logic [PC_W-1:0] mem_addr;
   logic [7:0]      mem_rdata;
   logic            loader_select, busy, done, error, pc_write;
   logic [PC_W-1:0] pc_next;

   logic [3:0] imem [0:65535];
   logic [7:0] dmem [0:65535];

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   assign instr     = imem[fetch_addr];
   assign mem_rdata = dmem[mem_addr];

   branch_sequencer #(.PC_W(PC_W), .DEPTH_W(8)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .mode(mode),
      .pc_in(pc_in), .cache_addr(cache_addr), .fetch_addr(fetch_addr),
      .instr(instr), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .loader_select(loader_select), .busy(busy), .done(done),
      .error(error), .pc_write(pc_write), .pc_next(pc_next)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_flags"}, {27'd0, busy, done, pc_write, error, loader_select}, 32'd0);
      chk({tag, "_addrs"}, {fetch_addr, mem_addr}, 32'd0);
      chk({tag, "_pcnext"}, {16'd0, pc_next}, 32'd0);
   endtask

   // walk the stream: bracket depth counting from pc+1 until the matching CBB
   function automatic void skip_model(input int pc, output int n, output int res, output bit err);
      int addr;
      int d;
      logic [3:0] op;
      addr = (pc + 1) & 'hFFFF;
      d    = 0;
      n    = 0;
      res  = 0;
      err  = 1'b0;
      while (n < 70000) begin
         n++;
         op = imem[addr];
         if (op == CBB && d == 0) begin
            res = (addr + 1) & 'hFFFF;
            return;
         end
         if (addr == 'hFFFF || (op == CBF && d == 255)) begin
            err = 1'b1;
            return;
         end
         if (op == CBF) d++;
         else if (op == CBB) d--;
         addr = (addr + 1) & 'hFFFF;
      end
   endfunction

   task automatic run_skip(input int pc, input bit dup_start, input int exp_res);
      int n, res;
      bit err, last;
      skip_model(pc, n, res, err);
      if (exp_res >= 0) res = exp_res;
      @(negedge clock);
      start = 1'b1; mode = 1'b0; pc_in = PC_W'(pc); cache_addr = PC_W'($urandom);
      @(negedge clock);
      start = 1'b0;
      for (int k = 1; k <= n; k++) begin
         if (k > 1) @(negedge clock);
         last = (k == n);
         chk("skip_busy", {31'd0, busy}, 32'd1);
         chk("skip_fetch", {16'd0, fetch_addr}, (pc + k) & 'hFFFF);
         chk("skip_done", {31'd0, done}, {31'd0, last});
         chk("skip_pcw", {31'd0, pc_write}, {31'd0, last && !err});
         chk("skip_err", {31'd0, error}, {31'd0, last && err});
         chk("skip_pcnext", {16'd0, pc_next}, (last && !err) ? res : 0);
         if (dup_start && k == 1) begin
            start = 1'b1; mode = 1'b1; pc_in = PC_W'(pc + 7); cache_addr = 16'h0100;
         end else begin
            start = 1'b0;
         end
      end
      @(negedge clock);
      start = 1'b0;
      chk_idle("skip_after");
   endtask

   task automatic run_restore(input int ca, input int exp);
      @(negedge clock);
      start = 1'b1; mode = 1'b1; cache_addr = PC_W'(ca); pc_in = PC_W'($urandom);
      @(negedge clock);
      start = 1'b0;
      chk("lo_busy", {31'd0, busy}, 32'd1);
      chk("lo_addr", {16'd0, mem_addr}, ca);
      chk("lo_sel_done_pcw", {29'd0, loader_select, done, pc_write}, 32'd0);
      @(negedge clock);
      chk("hi_addr", {16'd0, mem_addr}, (ca + 1) & 'hFFFF);
      chk("hi_sel_done_pcw", {29'd0, loader_select, done, pc_write}, 32'b100);
      @(negedge clock);
      chk("commit_flags", {27'd0, busy, done, pc_write, error, loader_select}, 32'b11100);
      chk("commit_pcnext", {16'd0, pc_next}, exp);
      chk("commit_memaddr", {16'd0, mem_addr}, 32'd0);
      @(negedge clock);
      chk_idle("restore_after");
   endtask

   initial begin
      int pc, ca;
      reset_n = 1'b0; start = 1'b0; mode = 1'b0; pc_in = '0; cache_addr = '0;
      for (int i = 0; i < 65536; i++) begin
         imem[i] = NOP;
         dmem[i] = 8'($urandom);
      end
      repeat (2) @(negedge clock);
      chk_idle("reset");
      reset_n = 1'b1;
      @(negedge clock);
      chk_idle("post_reset");

      // simple skip
      imem[16'h11] = INC; imem[16'h12] = MVR; imem[16'h13] = CBB;
      run_skip('h10, 1'b0, 'h14);
      // nested skip
      imem[16'h21] = CBF; imem[16'h22] = DEC; imem[16'h23] = CBB; imem[16'h24] = CBB;
      run_skip('h20, 1'b0, 'h25);
      // restore
      dmem[16'h100] = 8'h34; dmem[16'h101] = 8'h12;
      run_restore('h100, 'h1234);
      // scan wraps past all-ones
      imem[16'hFFFE] = INC; imem[16'hFFFF] = MVR;
      run_skip('hFFFD, 1'b0, -1);
      // depth overflow after 256 nested openers
      for (int i = 1; i <= 256; i++) imem[16'h8000 + i] = CBF;
      run_skip('h8000, 1'b0, -1);
      // a second start while scanning is ignored
      run_skip('h10, 1'b1, 'h14);
      run_skip('h20, 1'b1, 'h25);

      // reset during LOAD_HI
      @(negedge clock);
      start = 1'b1; mode = 1'b1; cache_addr = 16'h0100;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      chk("rst_in_loadhi_sel", {31'd0, loader_select}, 32'd1);
      reset_n = 1'b0;
      @(negedge clock);
      chk_idle("rst_mid_restore");
      reset_n = 1'b1;
      @(negedge clock);
      chk_idle("rst_mid_restore_hold");
      run_restore('h100, 'h1234);

      // reset mid-scan
      @(negedge clock);
      start = 1'b1; mode = 1'b0; pc_in = 16'h8000;
      @(negedge clock);
      start = 1'b0;
      repeat (5) @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      chk_idle("rst_mid_skip");
      reset_n = 1'b1;
      run_skip('h10, 1'b0, 'h14);

      // random bracket streams closed by a run of CBBs
      for (int t = 0; t < 20; t++) begin
         pc = int'($urandom_range(16'h0200, 16'h7000));
         for (int i = 1; i <= 30; i++)
            imem[pc + i] = ($urandom_range(0, 3) == 0) ? CBF :
                           ($urandom_range(0, 4) == 0) ? CBB : 4'($urandom_range(0, 6));
         for (int i = 31; i <= 70; i++) imem[pc + i] = CBB;
         run_skip(pc, t[0], -1);
      end

      // random restores, including the top-of-memory wrap
      for (int t = 0; t < 10; t++) begin
         ca = (t == 0) ? 'hFFFF : int'($urandom_range(0, 16'hFFFF));
         run_restore(ca, {16'd0, dmem[(ca + 1) & 'hFFFF], dmem[ca]});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 16, meaning program counter width in bits.
REQ-002 SHALL have parameter DEPTH_W, default 8, meaning bracket nesting counter width in bits.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request pulse from core when it leaves CORE_S.
REQ-006 SHALL have port mode, input, 1, 0 = SKIP (forward scan to matching CBB), 1 = RESTORE (reload PC from loop cache).
REQ-007 SHALL have port pc_in, input, PC_W, PC of the issuing bracket instruction, sampled with start.
REQ-008 SHALL have port cache_addr, input, PC_W, loop-cache entry address, sampled with start.
REQ-009 SHALL have port fetch_addr, output, PC_W, instruction-memory scan address.
REQ-010 SHALL have port instr, input, op_code, instruction at fetch_addr, valid in the same cycle.
REQ-011 SHALL have port mem_addr, output, PC_W, data-memory read address.
REQ-012 SHALL have port mem_rdata, input, 8, data-memory read byte, valid in the same cycle.
REQ-013 SHALL have port loader_select, output, 1, 0 = low PC byte being loaded, 1 = high byte.
REQ-014 SHALL have ports busy, done, error, pc_write (output, 1 each) and pc_next (output, PC_W).

Function
REQ-015 SHALL implement states IDLE, SKIP, LOAD_LO, LOAD_HI, COMMIT.
REQ-016 In IDLE, start=1 with mode=0 SHALL load scan_pc = pc_in+1, depth = 0, and enter SKIP.
REQ-017 In IDLE, start=1 with mode=1 SHALL latch cache_addr and enter LOAD_LO.
REQ-018 start while busy=1 SHALL be ignored.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 In SKIP, fetch_addr SHALL equal scan_pc; in all other states it SHALL be 0.
REQ-021 In SKIP, instr=CBF SHALL increment depth and scan_pc.
REQ-022 In SKIP, instr=CBB with depth>0 SHALL decrement depth and increment scan_pc.
REQ-023 In SKIP, instr=CBB with depth=0 SHALL, in that same cycle, drive pc_next = scan_pc+1, pc_write=1 and done=1, and SHALL return to IDLE.
REQ-024 In SKIP, any other instr SHALL increment scan_pc only.
REQ-025 In SKIP, an increment of scan_pc from all-ones (wrap) or of depth from all-ones (overflow) SHALL drive error=1, done=1, pc_write=0 that cycle and return to IDLE.
REQ-026 In LOAD_LO, mem_addr SHALL equal cache_addr and loader_select=0; mem_rdata SHALL be captured as the low byte.
REQ-027 In LOAD_HI, mem_addr SHALL equal cache_addr+1 (modulo 2^PC_W) and loader_select=1; mem_rdata SHALL be captured as the high byte.
REQ-028 In COMMIT, pc_next SHALL equal {high,low} truncated to PC_W, with pc_write=1 and done=1 for one cycle, followed by return to IDLE.
REQ-029 RESTORE latency SHALL be 3 cycles from the start cycle to the COMMIT cycle inclusive of LOAD_LO and LOAD_HI.
REQ-030 done, pc_write and error SHALL be single-cycle pulses.
REQ-031 When pc_write=0, pc_next SHALL be 0.
REQ-032 In non-load states, mem_addr and loader_select SHALL be 0.

Reset
REQ-033 With reset_n=0 at a clock edge, the block SHALL enter IDLE and clear scan_pc, depth and the captured bytes.
REQ-034 With reset_n=0 at a clock edge, all outputs SHALL be 0 in the following cycle.
REQ-035 Reset asserted mid-SKIP or mid-RESTORE SHALL abort the operation without a pc_write or done pulse.

Verification
REQ-036 SKIP, simple case: pc_in=0x0010, instr stream at 0x11..0x13 = INC, MVR, CBB -> done and pc_write in the 0x13 cycle, pc_next=0x0014, error=0.
REQ-037 SKIP, nested case: pc_in=0x0020, stream CBF, DEC, CBB, CBB at 0x21..0x24 -> depth goes 1 then 0, completion at 0x24, pc_next=0x0025.
REQ-038 RESTORE: cache_addr=0x0100, mem[0x100]=0x34, mem[0x101]=0x12 -> loader_select 0 then 1, COMMIT on cycle 3 with pc_next=0x1234 and pc_write=1.
REQ-039 Wrap error: pc_in=0xFFFD with no CBB in the stream -> error=1, done=1, pc_write=0 after scanning 0xFFFF, then busy=0.
REQ-040 Reset mid-op: start RESTORE, then reset_n=0 in LOAD_HI -> next cycle all outputs 0, no pc_write pulse, and a subsequent start is accepted normally.
REQ-041 start during busy: a second start issued in SKIP -> ignored; the result matches that of the first request alone.
